// File: rtl/placement_pkg.sv
//------------------------------------------------------------------------------
// Module   : placement_pkg
// Brief    : Shared structure-ID types and constants for row finder / allocator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package placement_pkg;

    localparam int NUM_STR = 13;
    localparam int ID_W    = 4;

    typedef logic [ID_W-1:0] str_id_t;

    localparam str_id_t STR_ID_NONE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } alloc_state_t;

endpackage

`default_nettype wire

// File: rtl/cand_pick.sv
//------------------------------------------------------------------------------
// Module   : cand_pick
// Brief    : Picks the first of three candidate IDs that is in range and free.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cand_pick #(
    parameter int NUM_STR = 13,
    parameter int ID_W    = 4
) (
    input  logic [ID_W-1:0]  id_1,
    input  logic [ID_W-1:0]  id_2,
    input  logic [ID_W-1:0]  id_3,
    input  logic [NUM_STR:1] occ,
    output logic             hit,
    output logic [ID_W-1:0]  pick_id
);

    import placement_pkg::*;

    // Matching against every legal index rejects 0 and out-of-range IDs for free.
    function automatic logic qualifies(input logic [ID_W-1:0] id, input logic [NUM_STR:1] occ_v);
        logic w_q;
        w_q = 1'b0;
        for (int i = 1; i <= NUM_STR; i++) begin
            if ((id == ID_W'(i)) && !occ_v[i]) begin
                w_q = 1'b1;
            end
        end
        return w_q;
    endfunction

    always_comb begin
        hit     = 1'b0;
        pick_id = ID_W'(STR_ID_NONE);
        if (qualifies(id_1, occ)) begin
            hit     = 1'b1;
            pick_id = id_1;
        end else if (qualifies(id_2, occ)) begin
            hit     = 1'b1;
            pick_id = id_2;
        end else if (qualifies(id_3, occ)) begin
            hit     = 1'b1;
            pick_id = id_3;
        end
    end

endmodule

`default_nettype wire

// File: rtl/row_allocator.sv
//------------------------------------------------------------------------------
// Module   : row_allocator
// Brief    : Grants the first free candidate structure, tracks occupancy and
//            releases, reports free capacity. ALLOC_STATS_EN adds counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module row_allocator #(
    parameter int NUM_STR = placement_pkg::NUM_STR,
    parameter int ID_W    = placement_pkg::ID_W
`ifdef ALLOC_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  str_id_1,
    input  logic [ID_W-1:0]  str_id_2,
    input  logic [ID_W-1:0]  str_id_3,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_ok,
    output logic [ID_W-1:0]  resp_id,
    input  logic             rel_valid,
    input  logic [ID_W-1:0]  rel_id,
    output logic             rel_err,
`ifdef ALLOC_STATS_EN
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] fail_cnt,
`endif
    output logic [ID_W-1:0]  free_count
);

    import placement_pkg::*;

    alloc_state_t     r_state;
    alloc_state_t     w_state_next;
    logic [ID_W-1:0]  r_id_1;
    logic [ID_W-1:0]  r_id_2;
    logic [ID_W-1:0]  r_id_3;
    logic [NUM_STR:1] r_occ;
    logic [NUM_STR:1] w_set_mask;
    logic [NUM_STR:1] w_clr_mask;
    logic             w_hit;
    logic [ID_W-1:0]  w_pick_id;
    logic             r_resp_ok;
    logic [ID_W-1:0]  r_resp_id;
    logic             r_rel_err;
    logic             w_rel_hit;
    logic [ID_W-1:0]  r_free_count;
    logic [ID_W-1:0]  w_occ_cnt;
    logic             w_load;
    logic             w_check;
    logic             w_resp_hs;

    cand_pick #(
        .NUM_STR (NUM_STR),
        .ID_W    (ID_W)
    ) u_cand_pick (
        .id_1    (r_id_1),
        .id_2    (r_id_2),
        .id_3    (r_id_3),
        .occ     (r_occ),
        .hit     (w_hit),
        .pick_id (w_pick_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_load       = 1'b0;
        w_check      = 1'b0;
        w_resp_hs    = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_load       = 1'b1;
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                w_check      = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_resp_hs    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Set only touches free bits and clear only occupied ones, so they never collide.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        w_rel_hit  = 1'b0;
        for (int i = 1; i <= NUM_STR; i++) begin
            if (w_check && w_hit && (w_pick_id == ID_W'(i))) begin
                w_set_mask[i] = 1'b1;
            end
            if (rel_valid && (rel_id == ID_W'(i)) && r_occ[i]) begin
                w_clr_mask[i] = 1'b1;
                w_rel_hit     = 1'b1;
            end
        end
    end

    always_comb begin
        w_occ_cnt = '0;
        for (int i = 1; i <= NUM_STR; i++) begin
            w_occ_cnt = w_occ_cnt + ID_W'(r_occ[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_1       <= '0;
            r_id_2       <= '0;
            r_id_3       <= '0;
            r_occ        <= '0;
            r_resp_ok    <= 1'b0;
            r_resp_id    <= '0;
            r_rel_err    <= 1'b0;
            r_free_count <= ID_W'(NUM_STR);
        end else begin
            if (w_load) begin
                r_id_1 <= str_id_1;
                r_id_2 <= str_id_2;
                r_id_3 <= str_id_3;
            end
            if (w_check) begin
                r_resp_ok <= w_hit;
                r_resp_id <= w_hit ? w_pick_id : ID_W'(STR_ID_NONE);
            end else if (w_resp_hs) begin
                r_resp_ok <= 1'b0;
                r_resp_id <= '0;
            end
            r_occ        <= (r_occ & ~w_clr_mask) | w_set_mask;
            r_rel_err    <= rel_valid && !w_rel_hit;
            r_free_count <= ID_W'(NUM_STR) - w_occ_cnt;
        end
    end

    assign resp_ok    = r_resp_ok;
    assign resp_id    = r_resp_id;
    assign rel_err    = r_rel_err;
    assign free_count = r_free_count;

`ifdef ALLOC_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= '0;
            r_fail_cnt  <= '0;
        end else if (w_resp_hs) begin
            if (r_resp_ok) begin
                if (r_grant_cnt != '1) begin
                    r_grant_cnt <= r_grant_cnt + CNT_W'(1);
                end
            end else if (r_fail_cnt != '1) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign fail_cnt  = r_fail_cnt;
`endif

endmodule

`default_nettype wire
